// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: FSM states and default word width shared by piso_serializer and sipo
package piso_serializer_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, FILL, GAP} state_t;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, LSB-first bit stream (plus all-ones fill frames) out to a sipo
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_fill,
  output logic                  in_ready,
  output logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_set_ones,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic accept, fill_req, frame_end;
  logic in_ready_n, ser_en_n, ser_data_n, ser_set_ones_n, frame_done_n, busy_n;

  always_comb begin
    accept = in_ready & in_valid;
    fill_req = in_ready & in_fill & ~in_valid;
    frame_end = (state == SHIFT && bit_cnt == LAST_BIT) || state == FILL;
    state_n = state;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    if (state == GAP) begin
      gap_cnt_n = gap_cnt + 1'b1;
      if (gap_cnt == LAST_GAP) state_n = IDLE;
    end else if (state == SHIFT && !frame_end) begin
      shreg_n = shreg >> 1;
      bit_cnt_n = bit_cnt + 1'b1;
    end else if (frame_end && GAP_CYCLES > 0) begin
      state_n = GAP;
      gap_cnt_n = '0;
    end else if (accept) begin
      state_n = SHIFT;
      shreg_n = in_data;
      bit_cnt_n = '0;
    end else if (fill_req) begin
      state_n = FILL;
    end else if (frame_end) begin
      state_n = IDLE;
    end
    // outputs are registered, so they are decoded from the next-cycle state
    in_ready_n = state_n == IDLE || (state_n == SHIFT && bit_cnt_n == LAST_BIT && GAP_CYCLES == 0);
    ser_en_n = state_n == SHIFT || state_n == FILL;
    ser_data_n = state_n == SHIFT && shreg_n[0];
    ser_set_ones_n = state_n == FILL;
    frame_done_n = (state_n == SHIFT && bit_cnt_n == LAST_BIT) || state_n == FILL;
    busy_n = state_n == SHIFT || state_n == GAP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      in_ready <= 1'b0;
      ser_en <= 1'b0;
      ser_data <= 1'b0;
      ser_set_ones <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      in_ready <= in_ready_n;
      ser_en <= ser_en_n;
      ser_data <= ser_data_n;
      ser_set_ones <= ser_set_ones_n;
      frame_done <= frame_done_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: two serializers (no gap / 2-cycle gap) on shared inputs, each feeding a sipo model
module tb_piso_serializer;
  logic clk, reset_n, in_valid, in_fill;
  logic [7:0] in_data;
  logic in_ready0, ser_en0, ser_data0, ser_set_ones0, frame_done0, busy0;
  logic in_ready2, ser_en2, ser_data2, ser_set_ones2, frame_done2, busy2;
  logic [7:0] sipo0, sipo2;
  logic [5:0] o0, o2;
  int n_checks = 0;
  int n_fail = 0;

  piso_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_fill(in_fill),
    .in_ready(in_ready0), .ser_en(ser_en0), .ser_data(ser_data0), .ser_set_ones(ser_set_ones0),
    .frame_done(frame_done0), .busy(busy0));

  piso_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_fill(in_fill),
    .in_ready(in_ready2), .ser_en(ser_en2), .ser_data(ser_data2), .ser_set_ones(ser_set_ones2),
    .frame_done(frame_done2), .busy(busy2));

  assign o0 = {in_ready0, ser_en0, ser_data0, ser_set_ones0, frame_done0, busy0};
  assign o2 = {in_ready2, ser_en2, ser_data2, ser_set_ones2, frame_done2, busy2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sipo0 <= '0;
      sipo2 <= '0;
    end else begin
      if (ser_en0) sipo0 <= ser_set_ones0 ? 8'hFF : {ser_data0, sipo0[7:1]};
      if (ser_en2) sipo2 <= ser_set_ones2 ? 8'hFF : {ser_data2, sipo2[7:1]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_fill = 1'b0;
    in_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_fill = 1'b0;
    in_data = '0;
    #3;
    n_checks++; if (o0 !== 6'b0) begin n_fail++; $display("FAIL reset_async0 got %b exp 000000", o0); end
    n_checks++; if (o2 !== 6'b0) begin n_fail++; $display("FAIL reset_async2 got %b exp 000000", o2); end
    tick();
    reset_n = 1'b1;
    n_checks++; if (o0 !== 6'b0) begin n_fail++; $display("FAIL reset_release0 got %b exp 000000", o0); end
    tick();
    n_checks++; if (o0 !== 6'b100000) begin n_fail++; $display("FAIL reset_ready0 got %b exp 100000", o0); end
    n_checks++; if (o2 !== 6'b100000) begin n_fail++; $display("FAIL reset_ready2 got %b exp 100000", o2); end
    n_checks++; if (sipo0 !== 8'h00) begin n_fail++; $display("FAIL reset_sipo got %h exp 00", sipo0); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 8'hA5 : 8'($urandom);
      in_valid = 1'b1;
      in_data = w;
      tick();
      in_valid = 1'b0;
      in_data = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (o0 !== {k == 7, 1'b1, w[k], 1'b0, k == 7, 1'b1}) begin
          n_fail++; $display("FAIL single w=%h bit%0d got %b exp %b", w, k, o0, {k == 7, 1'b1, w[k], 1'b0, k == 7, 1'b1});
        end
        tick();
      end
      n_checks++; if (o0 !== 6'b100000) begin n_fail++; $display("FAIL single_idle w=%h got %b exp 100000", w, o0); end
      n_checks++; if (sipo0 !== w) begin n_fail++; $display("FAIL single_sipo got %h exp %h", sipo0, w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [2];
    w[0] = 8'h3C;
    w[1] = 8'hC3;
    do_reset();
    in_valid = 1'b1;
    in_data = w[0];
    tick();
    in_data = w[1];
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (o0 !== {c % 8 == 7, 1'b1, w[c / 8][c % 8], 1'b0, c % 8 == 7, 1'b1}) begin
        n_fail++; $display("FAIL b2b cycle%0d got %b exp %b", c, o0, {c % 8 == 7, 1'b1, w[c / 8][c % 8], 1'b0, c % 8 == 7, 1'b1});
      end
      tick();
      if (c == 7) in_valid = 1'b0;
    end
    n_checks++; if (o0 !== 6'b100000) begin n_fail++; $display("FAIL b2b_idle got %b exp 100000", o0); end
    n_checks++; if (sipo0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_sipo got %h exp c3", sipo0); end
  endtask

  task automatic test_gap();
    logic [7:0] w [2];
    w[0] = 8'h01;
    w[1] = 8'h80;
    do_reset();
    in_valid = 1'b1;
    in_data = w[0];
    tick();
    in_data = w[1];
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o2 !== {1'b0, 1'b1, w[0][k], 1'b0, k == 7, 1'b1}) begin
        n_fail++; $display("FAIL gap_f1 bit%0d got %b exp %b", k, o2, {1'b0, 1'b1, w[0][k], 1'b0, k == 7, 1'b1});
      end
      tick();
    end
    n_checks++; if (sipo2 !== 8'h01) begin n_fail++; $display("FAIL gap_sipo1 got %h exp 01", sipo2); end
    for (int g = 0; g < 2; g++) begin
      n_checks++; if (o2 !== 6'b000001) begin n_fail++; $display("FAIL gap_idle%0d got %b exp 000001", g, o2); end
      tick();
    end
    n_checks++; if (o2 !== 6'b100000) begin n_fail++; $display("FAIL gap_ready got %b exp 100000", o2); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o2 !== {1'b0, 1'b1, w[1][k], 1'b0, k == 7, 1'b1}) begin
        n_fail++; $display("FAIL gap_f2 bit%0d got %b exp %b", k, o2, {1'b0, 1'b1, w[1][k], 1'b0, k == 7, 1'b1});
      end
      tick();
    end
    n_checks++; if (sipo2 !== 8'h80) begin n_fail++; $display("FAIL gap_sipo2 got %h exp 80", sipo2); end
    n_checks++; if (o2 !== 6'b000001) begin n_fail++; $display("FAIL gap_after got %b exp 000001", o2); end
  endtask

  task automatic test_fill();
    do_reset();
    in_fill = 1'b1;
    tick();
    in_fill = 1'b0;
    n_checks++; if (o0 !== 6'b010110) begin n_fail++; $display("FAIL fill got %b exp 010110", o0); end
    tick();
    n_checks++; if (o0 !== 6'b100000) begin n_fail++; $display("FAIL fill_idle got %b exp 100000", o0); end
    n_checks++; if (sipo0 !== 8'hFF) begin n_fail++; $display("FAIL fill_sipo got %h exp ff", sipo0); end
  endtask

  task automatic test_valid_and_fill();
    in_valid = 1'b1;
    in_fill = 1'b1;
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    in_fill = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o0 !== {k == 7, 1'b1, 1'b0, 1'b0, k == 7, 1'b1}) begin
        n_fail++; $display("FAIL vf bit%0d got %b exp %b", k, o0, {k == 7, 1'b1, 1'b0, 1'b0, k == 7, 1'b1});
      end
      tick();
    end
    n_checks++; if (sipo0 !== 8'h00) begin n_fail++; $display("FAIL vf_sipo got %h exp 00", sipo0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'h81;
    do_reset();
    in_valid = 1'b1;
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (o0 !== 6'b011001) begin n_fail++; $display("FAIL mid_bit3 got %b exp 011001", o0); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (o0 !== 6'b0) begin n_fail++; $display("FAIL mid_async got %b exp 000000", o0); end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (o0 !== 6'b100000) begin n_fail++; $display("FAIL mid_release got %b exp 100000", o0); end
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o0 !== {k == 7, 1'b1, w[k], 1'b0, k == 7, 1'b1}) begin
        n_fail++; $display("FAIL mid_frame bit%0d got %b exp %b", k, o0, {k == 7, 1'b1, w[k], 1'b0, k == 7, 1'b1});
      end
      tick();
    end
    n_checks++; if (sipo0 !== w) begin n_fail++; $display("FAIL mid_sipo got %h exp %h", sipo0, w); end
  endtask

  task automatic test_random();
    logic q[$];
    logic [7:0] wq[$];
    logic [7:0] pend;
    logic [5:0] want;
    bit chk = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      want = {q.size() <= 1, q.size() > 0, q.size() > 0 ? q[0] : 1'b0, 1'b0, q.size() == 1, q.size() > 0};
      n_checks++; if (o0 !== want) begin n_fail++; $display("FAIL rand cycle%0d got %b exp %b", c, o0, want); end
      if (chk) begin
        n_checks++; if (sipo0 !== pend) begin n_fail++; $display("FAIL rand_sipo cycle%0d got %h exp %h", c, sipo0, pend); end
        chk = 0;
      end
      if (q.size() == 1) begin
        pend = wq.pop_front();
        chk = 1;
      end
      in_valid = $urandom_range(0, 9) < 7;
      in_data = 8'($urandom);
      if (q.size() > 0) void'(q.pop_front());
      if (want[5] && in_valid) begin
        wq.push_back(in_data);
        for (int k = 0; k < 8; k++) q.push_back(in_data[k]);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_fill();
    test_valid_and_fill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
